// File: rtl/vga_sync_monitor.sv
// ---------------------------------------------------------------------------
// vga_sync_monitor
//
// Passive timing monitor for the 2-bit VGA output stage. It measures line
// length, frame height, active pixels per line, active lines per frame and a
// per-frame pixel checksum. It compares the results with the expected timing
// and runs a SEARCH / MEASURE / LOCKED lock state machine. It never drives
// the video path.
//
// Ports
//   clk           in   pixel clock (same clock as the video generator)
//   reset         in   asynchronous, active-high reset
//   Hs, Vs        in   horizontal / vertical sync (asserted level = SYNC_POL)
//   Blank         in   1 = visible pixel, 0 = blanking
//   R, G, B       in   2-bit colour components
//   h_total_meas  out  clocks between the last two Hs leading edges
//   v_total_meas  out  Hs leading edges in the last frame
//   act_px_meas   out  Blank=1 clocks in the last complete line
//   act_ln_meas   out  lines with active pixels in the last frame
//   checksum      out  sum of {R,G,B} over the last frame's active pixels
//   frame_pulse   out  one-cycle strobe when the frame results update
//   err_h         out  bad line length / active width, or Hs timeout
//   err_v         out  bad line count or active-line count
//   locked        out  timing good for LOCK_FRAMES consecutive frames
// ---------------------------------------------------------------------------
module vga_sync_monitor #(
    parameter int   H_TOTAL     = 1056,
    parameter int   H_ACTIVE    = 800,
    parameter int   V_TOTAL     = 628,
    parameter int   V_ACTIVE    = 600,
    parameter logic SYNC_POL    = 1'b1,
    parameter int   LOCK_FRAMES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Hs,
    input  logic        Vs,
    input  logic        Blank,
    input  logic [1:0]  R,
    input  logic [1:0]  G,
    input  logic [1:0]  B,
    output logic [11:0] h_total_meas,
    output logic [10:0] v_total_meas,
    output logic [11:0] act_px_meas,
    output logic [10:0] act_ln_meas,
    output logic [23:0] checksum,
    output logic        frame_pulse,
    output logic        err_h,
    output logic        err_v,
    output logic        locked
);

    localparam logic [1:0] SEARCH  = 2'd0;
    localparam logic [1:0] MEASURE = 2'd1;
    localparam logic [1:0] LOCKED  = 2'd2;

    localparam int GW = (LOCK_FRAMES < 2) ? 1 : $clog2(LOCK_FRAMES + 1);

    localparam logic [11:0] H_TOTAL_L  = H_TOTAL[11:0];
    localparam logic [11:0] H_ACTIVE_L = H_ACTIVE[11:0];
    localparam logic [10:0] V_TOTAL_L  = V_TOTAL[10:0];
    localparam logic [10:0] V_ACTIVE_L = V_ACTIVE[10:0];

    // Registered inputs and previous sync levels for edge detection.
    logic        hs_q, vs_q, blank_q, hs_prev_q, vs_prev_q;
    logic [5:0]  rgb_q;

    // Line / frame counters.
    logic [11:0] hcnt_q, hcnt_d;
    logic [11:0] apx_q, apx_d;
    logic [10:0] vline_q, vline_d;
    logic [10:0] aln_q, aln_d;
    logic [23:0] sum_q, sum_d;
    logic        line_bad_q, line_bad_d;
    logic        first_line_q, first_line_d;

    // Result registers and lock state.
    logic [11:0] h_total_q, h_total_d;
    logic [10:0] v_total_q, v_total_d;
    logic [11:0] act_px_q, act_px_d;
    logic [10:0] act_ln_q, act_ln_d;
    logic [23:0] checksum_q, checksum_d;
    logic        frame_pulse_q, frame_pulse_d;
    logic        err_h_q, err_h_d;
    logic        err_v_q, err_v_d;
    logic        locked_q, locked_d;
    logic [1:0]  state_q, state_d;
    logic [GW-1:0] gcnt_q, gcnt_d;

    // Per-cycle derived values.
    logic        hs_edge, vs_edge, line_check, timeout;
    logic [11:0] apx_inc;
    logic [10:0] vline_inc, aln_inc;
    logic [23:0] sum_inc;
    logic        line_bad_now, frame_err_v, frame_good;

    assign hs_edge = (hs_q == SYNC_POL) && (hs_prev_q != SYNC_POL);
    assign vs_edge = (vs_q == SYNC_POL) && (vs_prev_q != SYNC_POL);

    // The edge cycle's own pixel still belongs to the line being closed.
    assign apx_inc   = (blank_q && apx_q != 12'hFFF) ? apx_q + 12'd1 : apx_q;
    // A coincident Hs edge closes the last line of the frame being closed.
    assign vline_inc = (hs_edge && vline_q != 11'h7FF) ? vline_q + 11'd1 : vline_q;

    // The first line after SEARCH has an unknown start, so it is not judged.
    assign line_check = hs_edge && !first_line_q;

    assign aln_inc = (line_check && apx_inc != 12'd0 && aln_q != 11'h7FF)
                   ? aln_q + 11'd1 : aln_q;

    assign line_bad_now = line_bad_q |
                          (line_check & ((hcnt_q != H_TOTAL_L) |
                                         ((apx_inc != 12'd0) & (apx_inc != H_ACTIVE_L))));

    assign sum_inc     = sum_q + {18'd0, (blank_q ? rgb_q : 6'd0)};
    assign frame_err_v = (vline_inc != V_TOTAL_L) || (aln_inc != V_ACTIVE_L);
    assign frame_good  = !line_bad_now && !frame_err_v;

    // Fires once, on the clock where hcnt saturates.
    assign timeout = !hs_edge && (hcnt_q == 12'hFFE);

    always_comb begin
        // NOTE: every _d defaults to its _q before any branch, so no path
        // through this block can leave a signal unassigned and infer a latch.
        hcnt_d        = (hcnt_q == 12'hFFF) ? hcnt_q : hcnt_q + 12'd1;
        apx_d         = apx_inc;
        vline_d       = vline_inc;
        aln_d         = aln_inc;
        sum_d         = sum_inc;
        line_bad_d    = line_bad_now;
        first_line_d  = first_line_q;
        h_total_d     = h_total_q;
        v_total_d     = v_total_q;
        act_px_d      = act_px_q;
        act_ln_d      = act_ln_q;
        checksum_d    = checksum_q;
        frame_pulse_d = 1'b0;
        err_h_d       = err_h_q;
        err_v_d       = err_v_q;
        locked_d      = locked_q;
        state_d       = state_q;
        gcnt_d        = gcnt_q;

        // Line close.
        if (hs_edge) begin
            h_total_d    = hcnt_q;
            act_px_d     = apx_inc;
            hcnt_d       = 12'd1;
            apx_d        = 12'd0;
            first_line_d = 1'b0;
        end

        // Frame close, after the line close of the same cycle.
        if (vs_edge) begin
            vline_d    = 11'd0;
            aln_d      = 11'd0;
            sum_d      = 24'd0;
            line_bad_d = 1'b0;

            if (state_q == SEARCH) begin
                state_d = MEASURE;
            end else begin
                v_total_d     = vline_inc;
                act_ln_d      = aln_inc;
                checksum_d    = sum_inc;
                err_h_d       = line_bad_now;
                err_v_d       = frame_err_v;
                frame_pulse_d = 1'b1;

                if (state_q == MEASURE) begin
                    if (frame_good) begin
                        gcnt_d = gcnt_q + 1'b1;
                        if (int'(gcnt_q) + 1 >= LOCK_FRAMES) begin
                            state_d  = LOCKED;
                            locked_d = 1'b1;
                        end
                    end else begin
                        gcnt_d = '0;
                    end
                end else if (!frame_good) begin
                    state_d  = MEASURE;
                    locked_d = 1'b0;
                    gcnt_d   = '0;
                end
            end
        end

        // Hs timeout overrides any frame decision taken in the same cycle.
        if (timeout) begin
            err_h_d      = 1'b1;
            locked_d     = 1'b0;
            state_d      = SEARCH;
            gcnt_d       = '0;
            first_line_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hs_q          <= 1'b0;
            vs_q          <= 1'b0;
            blank_q       <= 1'b0;
            hs_prev_q     <= 1'b0;
            vs_prev_q     <= 1'b0;
            rgb_q         <= 6'd0;
            hcnt_q        <= 12'd0;
            apx_q         <= 12'd0;
            vline_q       <= 11'd0;
            aln_q         <= 11'd0;
            sum_q         <= 24'd0;
            line_bad_q    <= 1'b0;
            first_line_q  <= 1'b1;
            h_total_q     <= 12'd0;
            v_total_q     <= 11'd0;
            act_px_q      <= 12'd0;
            act_ln_q      <= 11'd0;
            checksum_q    <= 24'd0;
            frame_pulse_q <= 1'b0;
            err_h_q       <= 1'b0;
            err_v_q       <= 1'b0;
            locked_q      <= 1'b0;
            state_q       <= SEARCH;
            gcnt_q        <= '0;
        end else begin
            // NOTE: registers are written with non-blocking assignments so
            // every flop samples the values from before this clock edge.
            hs_q          <= Hs;
            vs_q          <= Vs;
            blank_q       <= Blank;
            hs_prev_q     <= hs_q;
            vs_prev_q     <= vs_q;
            rgb_q         <= {R, G, B};
            hcnt_q        <= hcnt_d;
            apx_q         <= apx_d;
            vline_q       <= vline_d;
            aln_q         <= aln_d;
            sum_q         <= sum_d;
            line_bad_q    <= line_bad_d;
            first_line_q  <= first_line_d;
            h_total_q     <= h_total_d;
            v_total_q     <= v_total_d;
            act_px_q      <= act_px_d;
            act_ln_q      <= act_ln_d;
            checksum_q    <= checksum_d;
            frame_pulse_q <= frame_pulse_d;
            err_h_q       <= err_h_d;
            err_v_q       <= err_v_d;
            locked_q      <= locked_d;
            state_q       <= state_d;
            gcnt_q        <= gcnt_d;
        end
    end

    assign h_total_meas = h_total_q;
    assign v_total_meas = v_total_q;
    assign act_px_meas  = act_px_q;
    assign act_ln_meas  = act_ln_q;
    assign checksum     = checksum_q;
    assign frame_pulse  = frame_pulse_q;
    assign err_h        = err_h_q;
    assign err_v        = err_v_q;
    assign locked       = locked_q;

endmodule

// File: tb/tb_vga_sync_monitor.sv
// ---------------------------------------------------------------------------
// tb_vga_sync_monitor
//
// Directed bench for vga_sync_monitor using the small timing variant
// (40 x 12 total, 32 x 8 active). A frame generator drives Hs/Vs/Blank/RGB.
// Every frame_pulse is captured with its cycle number and compared with a
// table of hand-computed per-frame results. Reset, Hs timeout and mid-frame
// reset are checked directly.
//
// Generator layout per line: Hs asserted for x = 0..3, Blank = 1 for
// x = 6..37 on lines y = 4..11, Vs asserted on lines y = 0..1. Vs and Hs
// rise together at x = 0, y = 0.
// ---------------------------------------------------------------------------
module tb_vga_sync_monitor;

    localparam int HT = 40;
    localparam int HA = 32;
    localparam int VT = 12;
    localparam int VA = 8;
    localparam int N_PULSES = 13;

    logic        clk = 1'b0;
    logic        reset;
    logic        Hs, Vs, Blank;
    logic [1:0]  R, G, B;
    logic [11:0] h_total_meas;
    logic [10:0] v_total_meas;
    logic [11:0] act_px_meas;
    logic [10:0] act_ln_meas;
    logic [23:0] checksum;
    logic        frame_pulse, err_h, err_v, locked;

    vga_sync_monitor #(
        .H_TOTAL    (HT),
        .H_ACTIVE   (HA),
        .V_TOTAL    (VT),
        .V_ACTIVE   (VA),
        .SYNC_POL   (1'b1),
        .LOCK_FRAMES(2)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .Hs          (Hs),
        .Vs          (Vs),
        .Blank       (Blank),
        .R           (R),
        .G           (G),
        .B           (B),
        .h_total_meas(h_total_meas),
        .v_total_meas(v_total_meas),
        .act_px_meas (act_px_meas),
        .act_ln_meas (act_ln_meas),
        .checksum    (checksum),
        .frame_pulse (frame_pulse),
        .err_h       (err_h),
        .err_v       (err_v),
        .locked      (locked)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int last_hs  = 0;
    int fstart [0:15];

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int cyc;
        int h, v, px, ln, cs, eh, ev, lk;
    } snap_t;

    typedef struct {
        int fidx;   // frame whose start produces this pulse
        int v, ln, cs, eh, ev, lk;
    } exp_t;

    snap_t snaps[$];
    exp_t  exp_tab [0:N_PULSES-1];

    always @(negedge clk) begin
        if (frame_pulse) begin
            snaps.push_back('{cyc, int'(h_total_meas), int'(v_total_meas),
                              int'(act_px_meas), int'(act_ln_meas), int'(checksum),
                              int'(err_h), int'(err_v), int'(locked)});
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic check_all_zero(input string pfx);
        check({pfx, "_htot"},   h_total_meas, 0);
        check({pfx, "_vtot"},   v_total_meas, 0);
        check({pfx, "_actpx"},  act_px_meas,  0);
        check({pfx, "_actln"},  act_ln_meas,  0);
        check({pfx, "_cksum"},  checksum,     0);
        check({pfx, "_pulse"},  frame_pulse,  0);
        check({pfx, "_err_h"},  err_h,        0);
        check({pfx, "_err_v"},  err_v,        0);
        check({pfx, "_locked"}, locked,       0);
    endtask

    // Drives one frame. short_y: line shortened to HT-1 clocks (-1 = none).
    // rst_y: line during which reset is pulsed at x = 20..22 (-1 = none).
    task automatic drive_frame(input int fidx, input logic [5:0] rgb,
                               input int n_lines, input int short_y, input int rst_y);
        for (int y = 0; y < n_lines; y++) begin
            int len;
            len = (y == short_y) ? HT - 1 : HT;
            for (int x = 0; x < len; x++) begin
                @(posedge clk);
                #1;
                if (x == 0 && y == 0) fstart[fidx] = cyc;
                if (x == 0) last_hs = cyc;
                Hs    = (x < 4);
                Vs    = (y < 2);
                Blank = (y >= 4 && y < 12 && x >= 6 && x < 6 + HA);
                {R, G, B} = rgb;
                if (y == rst_y && x == 20) begin
                    check("pre_rst_locked", locked, 1);
                    reset = 1'b1;
                    #1;
                    check_all_zero("midrst");
                end
                if (y == rst_y && x == 23) reset = 1'b0;
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Expected results: {frame start that closes it, v_total, act_ln,
        // checksum, err_h, err_v, locked}. Full active frame = 256 pixels.
        exp_tab[0]  = '{1,  12, 8, 16128, 0, 0, 0};
        exp_tab[1]  = '{2,  12, 8, 16128, 0, 0, 1};
        exp_tab[2]  = '{3,  12, 8, 1280,  0, 0, 1};  // rgb = 5
        exp_tab[3]  = '{4,  12, 8, 16128, 1, 0, 0};  // one 39-clock line
        exp_tab[4]  = '{5,  12, 8, 16128, 0, 0, 0};
        exp_tab[5]  = '{6,  12, 8, 16128, 0, 0, 1};  // relocked
        exp_tab[6]  = '{7,  11, 7, 14112, 0, 1, 0};  // 11-line frame
        exp_tab[7]  = '{8,  12, 8, 16128, 0, 0, 0};
        exp_tab[8]  = '{9,  12, 8, 16128, 0, 0, 1};
        exp_tab[9]  = '{11, 12, 8, 16128, 0, 0, 0};  // after Hs timeout
        exp_tab[10] = '{12, 12, 8, 16128, 0, 0, 1};
        exp_tab[11] = '{14, 12, 8, 16128, 0, 0, 0};  // after mid-frame reset
        exp_tab[12] = '{15, 12, 8, 16128, 0, 0, 1};

        reset = 1'b1;
        Hs = 1'b0; Vs = 1'b0; Blank = 1'b0; R = 2'd0; G = 2'd0; B = 2'd0;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("rst");
        reset = 1'b0;

        drive_frame(0, 6'd63, 12, -1, -1);
        drive_frame(1, 6'd63, 12, -1, -1);
        drive_frame(2, 6'd5,  12, -1, -1);
        drive_frame(3, 6'd63, 12,  5, -1);
        drive_frame(4, 6'd63, 12, -1, -1);
        drive_frame(5, 6'd63, 12, -1, -1);
        drive_frame(6, 6'd63, 11, -1, -1);
        drive_frame(7, 6'd63, 12, -1, -1);
        drive_frame(8, 6'd63, 12, -1, -1);
        drive_frame(9, 6'd63, 12, -1, -1);

        // Hs stopped: the timeout lands 4094 clocks after the last Hs edge
        // is processed (two clocks after it was driven).
        for (int i = 0; i < 4200; i++) begin
            @(posedge clk);
            #1;
            Hs = 1'b0; Vs = 1'b0; Blank = 1'b0;
            if (cyc == last_hs + 2 + 4093) begin
                check("tmo_before_locked", locked, 1);
                check("tmo_before_err_h",  err_h,  0);
            end
            if (cyc == last_hs + 2 + 4094) begin
                check("tmo_locked", locked, 0);
                check("tmo_err_h",  err_h,  1);
            end
        end

        drive_frame(10, 6'd63, 12, -1, -1);
        drive_frame(11, 6'd63, 12, -1, -1);
        drive_frame(12, 6'd63, 12, -1,  6);
        drive_frame(13, 6'd63, 12, -1, -1);
        drive_frame(14, 6'd63, 12, -1, -1);
        drive_frame(15, 6'd63, 12, -1, -1);
        repeat (4) @(posedge clk);
        #1;

        check("pulse_count", snaps.size(), N_PULSES);
        for (int i = 0; i < N_PULSES && i < snaps.size(); i++) begin
            check($sformatf("p%0d_cycle", i),  snaps[i].cyc, fstart[exp_tab[i].fidx] + 2);
            check($sformatf("p%0d_htot", i),   snaps[i].h,   HT);
            check($sformatf("p%0d_vtot", i),   snaps[i].v,   exp_tab[i].v);
            check($sformatf("p%0d_actpx", i),  snaps[i].px,  HA);
            check($sformatf("p%0d_actln", i),  snaps[i].ln,  exp_tab[i].ln);
            check($sformatf("p%0d_cksum", i),  snaps[i].cs,  exp_tab[i].cs);
            check($sformatf("p%0d_err_h", i),  snaps[i].eh,  exp_tab[i].eh);
            check($sformatf("p%0d_err_v", i),  snaps[i].ev,  exp_tab[i].ev);
            check($sformatf("p%0d_locked", i), snaps[i].lk,  exp_tab[i].lk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
